demux_router: RTL and testbench

- 1-to-2 registered demultiplexer with valid/ready handshakes. It is the inverse of the 2:1 address/data select in the RISC datapath.
- Takes one 10-bit word stream plus a select bit and steers each word to one of two downstream sinks, for example the branch-target path versus the sequential-PC path, or writeback port A versus port B.
- Each output owns a one-entry holding slot, so one stalled sink never corrupts the other sink's data.

---
 rtl/demux_pkg.sv | 12 +
 rtl/demux_slot.sv | 54 +++++
 rtl/demux_router.sv | 86 ++++++++
 tb/tb_demux_router.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-2 registered demultiplexer: word width and
// the per-output slot state encoding.
package demux_pkg;

    localparam int DEMUX_WIDTH = 10;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry output holding slot: loads on fill, empties on drain, and a
// same-cycle fill wins over the drain so a destination streams at 1 word/cycle.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_fill,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    slot_state_t      r_state;
    slot_state_t      w_next_state;
    logic [WIDTH-1:0] r_data;
    logic             w_drain;

    assign w_drain = (r_state == SLOT_FULL) && i_ready;

    // NOTE: every output of this block is given a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        if (i_fill) begin
            w_next_state = SLOT_FULL;
        end else if (w_drain) begin
            w_next_state = SLOT_EMPTY;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SLOT_EMPTY;
            // NOTE: the data register is cleared on reset as well, because the
            // word is visible on a port and must read 0 after reset.
            r_data  <= '0;
        end else begin
            r_state <= w_next_state;
            if (i_fill) begin
                r_data <= i_data;
            end
        end
    end

    assign o_valid = (r_state == SLOT_FULL);
    assign o_data  = r_data;

endmodule

// File: rtl/demux_router.sv
// 1-to-2 registered demultiplexer with valid/ready handshakes on every port.
// Optional transfer counters cnt0/cnt1 are enabled by DEMUX_ROUTER_COUNT_EN.
module demux_router
    import demux_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_sel,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready
`ifdef DEMUX_ROUTER_COUNT_EN
    ,
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1
`endif
);

    logic w_slot0_free;
    logic w_slot1_free;
    logic w_accept;
    logic w_fill0;
    logic w_fill1;

    // A slot can take a word if it is empty or is being drained this cycle;
    // only the selected slot gates the source.
    assign w_slot0_free = !out0_valid || out0_ready;
    assign w_slot1_free = !out1_valid || out1_ready;
    assign in_ready     = in_sel ? w_slot1_free : w_slot0_free;

    assign w_accept = in_valid && in_ready;
    assign w_fill0  = w_accept && !in_sel;
    assign w_fill1  = w_accept && in_sel;

    demux_slot #(.WIDTH(WIDTH)) u_slot0 (
        .clk     (clk),
        .rst     (rst),
        .i_fill  (w_fill0),
        .i_data  (in_data),
        .i_ready (out0_ready),
        .o_valid (out0_valid),
        .o_data  (out0_data)
    );

    demux_slot #(.WIDTH(WIDTH)) u_slot1 (
        .clk     (clk),
        .rst     (rst),
        .i_fill  (w_fill1),
        .i_data  (in_data),
        .i_ready (out1_ready),
        .o_valid (out1_valid),
        .o_data  (out1_data)
    );

`ifdef DEMUX_ROUTER_COUNT_EN
    logic [15:0] r_cnt0;
    logic [15:0] r_cnt1;

    // Counters wrap naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (out0_valid && out0_ready) begin
                r_cnt0 <= r_cnt0 + 16'd1;
            end
            if (out1_valid && out1_ready) begin
                r_cnt1 <= r_cnt1 + 16'd1;
            end
        end
    end

    assign cnt0 = r_cnt0;
    assign cnt1 = r_cnt1;
`endif

endmodule

// File: tb/tb_demux_router.sv
// Directed self-checking bench for demux_router; the counter-wrap scenario is
// compiled in only when DEMUX_ROUTER_COUNT_EN is defined.
module tb_demux_router;

    localparam int WIDTH = 10;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_sel;
    logic             in_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out1_data;
    logic             out1_valid;
    logic             out1_ready;
`ifdef DEMUX_ROUTER_COUNT_EN
    logic [15:0]      cnt0;
    logic [15:0]      cnt1;
`endif

    int errors = 0;
    int checks = 0;

    demux_router #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_sel     (in_sel),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready)
`ifdef DEMUX_ROUTER_COUNT_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to just after the next rising edge; outputs are sampled here and
    // inputs for the following edge are driven here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 10'h3FF;
        out0_ready = 1'b0; out1_ready = 1'b0;
        step();
        step();
        checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL reset_out0_valid: got %b expected 0", out0_valid); end
        checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL reset_out1_valid: got %b expected 0", out1_valid); end
        checks++; if (out0_data !== 10'h000) begin errors++; $display("FAIL reset_out0_data: got %h expected 000", out0_data); end
        checks++; if (out1_data !== 10'h000) begin errors++; $display("FAIL reset_out1_data: got %h expected 000", out1_data); end
        rst = 1'b0; in_valid = 1'b0;
        step();
        checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL reset_no_capture: got out0_valid=%b expected 0", out0_valid); end
    endtask

    task automatic test_basic_routing();
        out0_ready = 1'b1; out1_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 10'h155;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready0: got %b expected 1", in_ready); end
        step();
        checks++; if (out0_valid !== 1'b1 || out0_data !== 10'h155) begin errors++; $display("FAIL basic_out0: got v=%b d=%h expected v=1 d=155", out0_valid, out0_data); end
        checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL basic_out1_idle: got %b expected 0", out1_valid); end
        in_sel = 1'b1; in_data = 10'h2AA;
        step();
        checks++; if (out1_valid !== 1'b1 || out1_data !== 10'h2AA) begin errors++; $display("FAIL basic_out1: got v=%b d=%h expected v=1 d=2AA", out1_valid, out1_data); end
        checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL basic_out0_pulse: got %b expected 0", out0_valid); end
        in_valid = 1'b0;
        step();
        checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL basic_out1_pulse: got %b expected 0", out1_valid); end
    endtask

    task automatic test_back_pressure();
        out0_ready = 1'b0; out1_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 10'h001;
        step();
        in_data = 10'h002;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_stalled: got %b expected 0", in_ready); end
        step();
        checks++; if (out0_valid !== 1'b1 || out0_data !== 10'h001) begin errors++; $display("FAIL bp_out0_held: got v=%b d=%h expected v=1 d=001", out0_valid, out0_data); end
        in_sel = 1'b1; in_data = 10'h3FF;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_other: got %b expected 1", in_ready); end
        step();
        checks++; if (out1_valid !== 1'b1 || out1_data !== 10'h3FF) begin errors++; $display("FAIL bp_out1: got v=%b d=%h expected v=1 d=3FF", out1_valid, out1_data); end
        checks++; if (out0_valid !== 1'b1 || out0_data !== 10'h001) begin errors++; $display("FAIL bp_out0_still_held: got v=%b d=%h expected v=1 d=001", out0_valid, out0_data); end
        // Release sink 0: 0x001 leaves on this edge while 0x002 loads behind it.
        in_sel = 1'b0; in_data = 10'h002; out0_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_release: got %b expected 1", in_ready); end
        step();
        checks++; if (out0_valid !== 1'b1 || out0_data !== 10'h002) begin errors++; $display("FAIL bp_out0_second: got v=%b d=%h expected v=1 d=002", out0_valid, out0_data); end
        checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL bp_out1_drained: got %b expected 0", out1_valid); end
        in_valid = 1'b0;
        step();
        checks++; if (out0_valid !== 1'b0) begin errors++; $display("FAIL bp_out0_drained: got %b expected 0", out0_valid); end
    endtask

    task automatic test_streaming();
        int received = 0;
        out0_ready = 1'b1; out1_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0;
        for (int i = 0; i < 16; i++) begin
            in_data = WIDTH'(i);
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", i, in_ready); end
            step();
            checks++;
            if (out0_valid !== 1'b1 || out0_data !== WIDTH'(i)) begin
                errors++; $display("FAIL stream_word[%0d]: got v=%b d=%h expected v=1 d=%h", i, out0_valid, out0_data, WIDTH'(i));
            end else begin
                received++;
            end
        end
        // Don't-care data and select with in_valid low must leave both slots idle.
        in_valid = 1'b0; in_sel = 1'b1; in_data = 10'h3AB;
        step();
        checks++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin errors++; $display("FAIL stream_idle: got v0=%b v1=%b expected 0 0", out0_valid, out1_valid); end
        checks++; if (received !== 16) begin errors++; $display("FAIL stream_count: got %0d expected 16", received); end
    endtask

    task automatic test_reset_mid_stall();
        out1_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b1; in_data = 10'h123;
        step();
        checks++; if (out1_valid !== 1'b1 || out1_data !== 10'h123) begin errors++; $display("FAIL stall_loaded: got v=%b d=%h expected v=1 d=123", out1_valid, out1_data); end
        in_valid = 1'b0; rst = 1'b1;
        step();
        checks++; if (out1_valid !== 1'b0 || out1_data !== 10'h000) begin errors++; $display("FAIL stall_reset: got v=%b d=%h expected v=0 d=000", out1_valid, out1_data); end
        rst = 1'b0; out1_ready = 1'b1;
        step();
        checks++; if (out1_valid !== 1'b0) begin errors++; $display("FAIL stall_never_delivered: got %b expected 0", out1_valid); end
    endtask

`ifdef DEMUX_ROUTER_COUNT_EN
    task automatic test_counter_wrap();
        rst = 1'b1; in_valid = 1'b0;
        step();
        rst = 1'b0;
        out0_ready = 1'b1; out1_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b1; in_data = 10'h0F0;
        repeat (65537) step();
        in_valid = 1'b0;
        step();
        checks++; if (cnt1 !== 16'd1) begin errors++; $display("FAIL cnt1_wrap: got %0d expected 1", cnt1); end
        checks++; if (cnt0 !== 16'd0) begin errors++; $display("FAIL cnt0_idle: got %0d expected 0", cnt0); end
    endtask
`endif

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        out0_ready = 1'b0; out1_ready = 1'b0;
        test_reset();
        test_basic_routing();
        test_back_pressure();
        test_streaming();
        test_reset_mid_stall();
`ifdef DEMUX_ROUTER_COUNT_EN
        test_counter_wrap();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
